// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared definitions for the ID-stage hazard and forwarding controller:
// forwarding select codes, FSM state encoding and the forward-priority helper.
package hazard_fwd_ctrl_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EXM = 2'b01;
  localparam logic [1:0] FWD_WBA = 2'b10;
  localparam logic [1:0] FWD_WBL = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_LU_STALL = 2'b01,
    ST_FLUSH    = 2'b10
  } hz_state_e;

  // A matching load one stage ahead cannot be forwarded, so it falls through to MEM
  function automatic logic [1:0] fwd_encode(input logic ex_hit, input logic ex_ld,
                                            input logic mem_hit, input logic mem_ld);
    logic [1:0] sel;
    sel = FWD_RF;
    if (ex_hit && !ex_ld) begin
      sel = FWD_EXM;
    end else if (mem_hit) begin
      sel = mem_ld ? FWD_WBL : FWD_WBA;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_shadow.sv
// One shadow entry {write, load, dest} mirroring an instruction ahead of ID;
// a clear loads a bubble instead of the incoming entry.
module hz_shadow_stage #(
  parameter int REG_W = 5
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             i_clr,
  input  logic             i_wr,
  input  logic             i_ld,
  input  logic [REG_W-1:0] i_rd,
  output logic             o_wr,
  output logic             o_ld,
  output logic [REG_W-1:0] o_rd
);

  logic             r_wr;
  logic             r_ld;
  logic [REG_W-1:0] r_rd;

  // Capture the entry, or a bubble when cleared
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_wr <= 1'b0;
      r_ld <= 1'b0;
      r_rd <= {REG_W{1'b0}};
    end else if (i_clr) begin
      r_wr <= 1'b0;
      r_ld <= 1'b0;
      r_rd <= {REG_W{1'b0}};
    end else begin
      r_wr <= i_wr;
      r_ld <= i_ld;
      r_rd <= i_rd;
    end
  end

  assign o_wr = r_wr;
  assign o_ld = r_ld;
  assign o_rd = r_rd;

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// ID-stage hazard unit: forwarding selects for ID/EX, load-use bubble (stall)
// and taken-branch flush (stallstall), from shadows of the EX and MEM instructions.
module hazard_fwd_ctrl
  import hazard_fwd_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int REG_W        = 5
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [REG_W-1:0] ID_rs,
  input  logic [REG_W-1:0] ID_rt,
  input  logic             ID_UsesRs,
  input  logic             ID_UsesRt,
  input  logic             ID_RegWrite,
  input  logic             ID_MemtoReg,
  input  logic [REG_W-1:0] ID_WriteReg,
  input  logic             EX_BranchTaken,
  output logic             stall,
  output logic             stallstall,
  output logic             PC_hold,
  output logic [1:0]       ID_FwdA,
  output logic [1:0]       ID_FwdB
);

  localparam logic [1:0] CNT_INIT = 2'(FLUSH_CYCLES - 1);

  hz_state_e        r_state;
  hz_state_e        w_state_nxt;
  logic [1:0]       r_cnt;
  logic [1:0]       w_cnt_nxt;
  logic             w_stall;
  logic             w_stallstall;
  logic             w_bubble;

  logic             w_ex_wr, w_ex_ld, w_mem_wr, w_mem_ld;
  logic [REG_W-1:0] w_ex_rd, w_mem_rd;
  logic             w_ex_hit_a, w_ex_hit_b, w_mem_hit_a, w_mem_hit_b;
  logic             w_lu;

  // $zero never matches, so it is never forwarded or stalled on
  function automatic logic src_hit(input logic wr, input logic [REG_W-1:0] rd,
                                   input logic [REG_W-1:0] src, input logic uses);
    return wr && uses && (rd != {REG_W{1'b0}}) && (rd == src);
  endfunction

  assign w_bubble = w_stall | w_stallstall;

  hz_shadow_stage #(.REG_W(REG_W)) u_ex_shadow (
    .Clk   (Clk),
    .Reset (Reset),
    .i_clr (w_bubble),
    .i_wr  (ID_RegWrite),
    .i_ld  (ID_MemtoReg),
    .i_rd  (ID_WriteReg),
    .o_wr  (w_ex_wr),
    .o_ld  (w_ex_ld),
    .o_rd  (w_ex_rd)
  );

  hz_shadow_stage #(.REG_W(REG_W)) u_mem_shadow (
    .Clk   (Clk),
    .Reset (Reset),
    .i_clr (1'b0),
    .i_wr  (w_ex_wr),
    .i_ld  (w_ex_ld),
    .i_rd  (w_ex_rd),
    .o_wr  (w_mem_wr),
    .o_ld  (w_mem_ld),
    .o_rd  (w_mem_rd)
  );

  assign w_ex_hit_a  = src_hit(w_ex_wr,  w_ex_rd,  ID_rs, ID_UsesRs);
  assign w_ex_hit_b  = src_hit(w_ex_wr,  w_ex_rd,  ID_rt, ID_UsesRt);
  assign w_mem_hit_a = src_hit(w_mem_wr, w_mem_rd, ID_rs, ID_UsesRs);
  assign w_mem_hit_b = src_hit(w_mem_wr, w_mem_rd, ID_rt, ID_UsesRt);
  assign w_lu        = w_ex_ld & (w_ex_hit_a | w_ex_hit_b);

  // State and flush-counter registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= ST_RUN;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state; stall is raised in RUN the cycle the hazard is seen, a branch wins over it
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_stall      = 1'b0;
    w_stallstall = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (EX_BranchTaken) begin
          w_state_nxt = ST_FLUSH;
          w_cnt_nxt   = CNT_INIT;
        end else if (w_lu) begin
          w_state_nxt = ST_LU_STALL;
          w_stall     = 1'b1;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_LU_STALL: begin
        if (EX_BranchTaken) begin
          w_state_nxt = ST_FLUSH;
          w_cnt_nxt   = CNT_INIT;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_FLUSH: begin
        w_stallstall = 1'b1;
        if (r_cnt == 2'd0) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_cnt_nxt = r_cnt - 2'd1;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_cnt_nxt   = 2'd0;
      end
    endcase
  end

  assign stall      = w_stall;
  assign stallstall = w_stallstall;
  assign PC_hold    = w_stall & ~w_stallstall;
  assign ID_FwdA    = w_bubble ? FWD_RF : fwd_encode(w_ex_hit_a, w_ex_ld, w_mem_hit_a, w_mem_ld);
  assign ID_FwdB    = w_bubble ? FWD_RF : fwd_encode(w_ex_hit_b, w_ex_ld, w_mem_hit_b, w_mem_ld);

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Self-checking bench for hazard_fwd_ctrl: directed hazard scenarios followed by
// random instruction streams, all compared against a pipeline-occupancy model.
module tb_hazard_fwd_ctrl;

  localparam int FC = 2;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [4:0] ID_rs, ID_rt, ID_WriteReg;
  logic       ID_UsesRs, ID_UsesRt, ID_RegWrite, ID_MemtoReg, EX_BranchTaken;
  logic       stall, stallstall, PC_hold;
  logic [1:0] ID_FwdA, ID_FwdB;

  hazard_fwd_ctrl #(.FLUSH_CYCLES(FC), .REG_W(5)) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .ID_rs          (ID_rs),
    .ID_rt          (ID_rt),
    .ID_UsesRs      (ID_UsesRs),
    .ID_UsesRt      (ID_UsesRt),
    .ID_RegWrite    (ID_RegWrite),
    .ID_MemtoReg    (ID_MemtoReg),
    .ID_WriteReg    (ID_WriteReg),
    .EX_BranchTaken (EX_BranchTaken),
    .stall          (stall),
    .stallstall     (stallstall),
    .PC_hold        (PC_hold),
    .ID_FwdA        (ID_FwdA),
    .ID_FwdB        (ID_FwdB)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic       wr;
    logic       ld;
    logic [4:0] rd;
  } ent_t;

  // ahead[0] is the instruction one stage ahead of ID (EX), ahead[1] two stages (MEM)
  ent_t ahead [2];
  int   flush_left;
  bit   after_stall;
  int   n_total = 0;
  int   n_bad   = 0;
  logic       exp_stall, exp_ss;
  logic [1:0] exp_fa, exp_fb;

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit writes_src(ent_t e, logic [4:0] src, logic uses);
    return uses && e.wr && (e.rd != 5'd0) && (e.rd == src);
  endfunction

  // Nearest producer wins; a load at distance 1 cannot supply data and is skipped
  function automatic logic [1:0] pick(logic [4:0] src, logic uses);
    for (int d = 0; d < 2; d++) begin
      if (writes_src(ahead[d], src, uses)) begin
        if (d == 0) begin
          if (!ahead[0].ld) return 2'd1;
        end else begin
          return ahead[1].ld ? 2'd3 : 2'd2;
        end
      end
    end
    return 2'd0;
  endfunction

  task automatic model_reset();
    ahead[0] = '0;
    ahead[1] = '0;
    flush_left  = 0;
    after_stall = 1'b0;
  endtask

  task automatic model_eval();
    bit lu;
    exp_ss = (flush_left > 0);
    lu = ahead[0].ld && (writes_src(ahead[0], ID_rs, ID_UsesRs) || writes_src(ahead[0], ID_rt, ID_UsesRt));
    exp_stall = !exp_ss && !after_stall && lu && !EX_BranchTaken;
    if (exp_stall || exp_ss) begin
      exp_fa = 2'd0;
      exp_fb = 2'd0;
    end else begin
      exp_fa = pick(ID_rs, ID_UsesRs);
      exp_fb = pick(ID_rt, ID_UsesRt);
    end
  endtask

  task automatic model_update();
    ahead[1] = ahead[0];
    ahead[0] = (exp_stall || exp_ss) ? ent_t'('0) : ent_t'({ID_RegWrite, ID_MemtoReg, ID_WriteReg});
    if (flush_left > 0) flush_left--;
    else if (EX_BranchTaken) flush_left = FC;
    after_stall = exp_stall;
  endtask

  task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic urs, input logic urt,
                        input logic wr, input logic ld, input logic [4:0] wrd, input logic br);
    ID_rs = rs; ID_rt = rt; ID_UsesRs = urs; ID_UsesRt = urt;
    ID_RegWrite = wr; ID_MemtoReg = ld; ID_WriteReg = wrd; EX_BranchTaken = br;
  endtask

  // Called at a falling edge with inputs applied; returns at the next falling edge
  task automatic cycle();
    #1;
    model_eval();
    chk("stall",      stall,      exp_stall);
    chk("stallstall", stallstall, exp_ss);
    chk("pc_hold",    PC_hold,    exp_stall & ~exp_ss);
    chk("fwd_a",      ID_FwdA,    exp_fa);
    chk("fwd_b",      ID_FwdB,    exp_fb);
    @(posedge Clk);
    model_update();
    @(negedge Clk);
  endtask

  initial begin
    Reset = 1'b1;
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    model_reset();
    repeat (2) @(negedge Clk);
    #1;
    chk("rst_stall", stall, 2'd0);
    chk("rst_ss",    stallstall, 2'd0);
    chk("rst_fwd_a", ID_FwdA, 2'd0);
    chk("rst_fwd_b", ID_FwdB, 2'd0);
    Reset = 1'b0;

    // EX ALU result forwarded to rs
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd3, 1'b0); cycle();
    set_id(5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    #1; chk("d1_fwd_a", ID_FwdA, 2'd1); chk("d1_stall", stall, 2'd0);
    cycle();

    // load-use: one bubble, then load data from MEM/WB
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0); cycle();
    set_id(5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, 5'd6, 1'b0);
    #1; chk("d2_stall", stall, 2'd1); chk("d2_pc_hold", PC_hold, 2'd1);
    cycle();
    #1; chk("d2_fwd_b", ID_FwdB, 2'd3); chk("d2_stall_after", stall, 2'd0);
    cycle();

    // taken branch: flush for FC cycles
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1); cycle();
    set_id(5'd6, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 5'd4, 1'b0);
    #1; chk("d3_ss1", stallstall, 2'd1); chk("d3_pc_hold", PC_hold, 2'd0); chk("d3_fwd_a", ID_FwdA, 2'd0);
    cycle();
    #1; chk("d3_ss2", stallstall, 2'd1);
    cycle();
    #1; chk("d3_ss_end", stallstall, 2'd0);
    cycle();

    // load-use and branch together: branch wins
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0); cycle();
    set_id(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
    #1; chk("d4_stall", stall, 2'd0);
    cycle();
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    #1; chk("d4_ss", stallstall, 2'd1);
    cycle(); cycle();

    // writes to r0 are never forwarded
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0); cycle();
    set_id(5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    #1; chk("d5_fwd_a", ID_FwdA, 2'd0); chk("d5_stall", stall, 2'd0);
    cycle();

    // reset in the middle of a flush
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd7, 1'b1); cycle();
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    #1; chk("d6_ss_before", stallstall, 2'd1);
    Reset = 1'b1;
    #1; chk("d6_ss_async", stallstall, 2'd0); chk("d6_stall_async", stall, 2'd0);
    model_reset();
    @(negedge Clk);
    Reset = 1'b0;
    set_id(5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    #1; chk("d6_fwd_a", ID_FwdA, 2'd0); chk("d6_fwd_b", ID_FwdB, 2'd0);
    cycle();

    // random instruction stream over a small register window to provoke hazards
    for (int i = 0; i < 600; i++) begin
      set_id(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 3),
             5'($urandom_range(0, 3)), 1'($urandom_range(0, 11) == 0));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
